// File: rtl/mdu_pkg.sv
// Shared types and R-type funct codes for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_t;
    typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_DONE} mdu_state_t;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;

endpackage

// File: rtl/mdu_iter.sv
// One iteration of the MDU datapath on the {acc, opd} pair: right-shifting
// shift-add for multiply, left-shifting restoring shift-subtract for divide.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] opd_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] opd_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   add;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum  = {1'b0, acc_i} + {1'b0, b_i};
        add  = opd_i[0] ? sum : {1'b0, acc_i};
        rem  = {acc_i, opd_i[WIDTH-1]};
        ge   = (rem >= {1'b0, b_i});
        // when ge holds the true difference is below b, so WIDTH bits suffice
        diff = rem[WIDTH-1:0] - b_i;
        if (is_div_i) begin
            acc_o = ge ? diff : rem[WIDTH-1:0];
            opd_o = {opd_i[WIDTH-2:0], ge};
        end else begin
            acc_o = add[WIDTH:1];
            opd_o = {add[0], opd_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall.
// state | meaning: IDLE accepts ops and moves; RUN iterates; DONE commits HI/LO.
module muldiv_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_mdu_clk,
    input  logic             i_mdu_rst,
    input  logic             i_mdu_start,
    input  logic [1:0]       i_mdu_op,
    input  logic [WIDTH-1:0] i_mdu_rs,
    input  logic [WIDTH-1:0] i_mdu_rt,
    input  logic             i_mdu_mthi,
    input  logic             i_mdu_mtlo,
    input  logic [WIDTH-1:0] i_mdu_wdata,
    input  logic             i_mdu_mfreq,
    output logic             o_mdu_busy,
    output logic             o_mdu_stall,
    output logic             o_mdu_done,
    output logic             o_mdu_divzero,
    output logic [WIDTH-1:0] o_mdu_hi,
    output logic [WIDTH-1:0] o_mdu_lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, opd_q, opd_d, b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic [WIDTH-1:0]   acc_nx, opd_nx;
    logic               op_div, op_signed, sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opd_i    (opd_q),
        .b_i      (b_q),
        .acc_o    (acc_nx),
        .opd_o    (opd_nx)
    );

    assign op_div    = (i_mdu_op == MDU_DIV) || (i_mdu_op == MDU_DIVU);
    assign op_signed = (i_mdu_op == MDU_MULT) || (i_mdu_op == MDU_DIV);
    assign sa        = op_signed & i_mdu_rs[WIDTH-1];
    assign sb        = op_signed & i_mdu_rt[WIDTH-1];
    assign abs_a     = sa ? -i_mdu_rs : i_mdu_rs;
    assign abs_b     = sb ? -i_mdu_rt : i_mdu_rt;

    // magnitude results are negated as needed; 0x80000000/-1 wraps back to 0x80000000
    assign prod_fix  = neg_q ? -{acc_q, opd_q} : {acc_q, opd_q};
    assign quo_fix   = neg_q ? -opd_q : opd_q;
    assign rem_fix   = rneg_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        case (state_q)
            MDU_IDLE: begin
                if (i_mdu_start) begin
                    is_div_d = op_div;
                    if (op_div && (i_mdu_rt == '0)) begin
                        dz_d    = 1'b1;
                        state_d = MDU_DONE;
                    end else begin
                        dz_d    = 1'b0;
                        acc_d   = '0;
                        opd_d   = abs_a;
                        b_d     = abs_b;
                        neg_d   = sa ^ sb;
                        rneg_d  = sa;
                        cnt_d   = '0;
                        state_d = MDU_RUN;
                    end
                end else begin
                    if (i_mdu_mthi) hi_d = i_mdu_wdata;
                    if (i_mdu_mtlo) lo_d = i_mdu_wdata;
                end
            end
            MDU_RUN: begin
                acc_d = acc_nx;
                opd_d = opd_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) state_d = MDU_DONE;
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
                dz_d    = 1'b0;
                if (!dz_q) begin
                    if (is_div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge i_mdu_clk or posedge i_mdu_rst) begin
        if (i_mdu_rst) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
        end
    end

    assign o_mdu_busy    = (state_q != MDU_IDLE);
    assign o_mdu_done    = (state_q == MDU_DONE);
    assign o_mdu_divzero = o_mdu_done & dz_q;
    assign o_mdu_stall   = o_mdu_busy & (i_mdu_start | i_mdu_mfreq | i_mdu_mthi | i_mdu_mtlo);
    assign o_mdu_hi      = hi_q;
    assign o_mdu_lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against an arithmetic HI/LO model.
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic         clk, rst, start, mthi, mtlo, mfreq;
    logic [1:0]   op;
    logic [W-1:0] rs, rt, wdata;
    logic         busy, stall, done, divzero;
    logic [W-1:0] hi, lo;

    logic [W-1:0] m_hi, m_lo;
    int           n_chk, n_pass;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .i_mdu_clk     (clk),
        .i_mdu_rst     (rst),
        .i_mdu_start   (start),
        .i_mdu_op      (op),
        .i_mdu_rs      (rs),
        .i_mdu_rt      (rt),
        .i_mdu_mthi    (mthi),
        .i_mdu_mtlo    (mtlo),
        .i_mdu_wdata   (wdata),
        .i_mdu_mfreq   (mfreq),
        .o_mdu_busy    (busy),
        .o_mdu_stall   (stall),
        .o_mdu_done    (done),
        .o_mdu_divzero (divzero),
        .o_mdu_hi      (hi),
        .o_mdu_lo      (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Architectural result of one MDU op; returns divide-by-zero flag.
    function automatic bit model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 inout logic [W-1:0] h, inout logic [W-1:0] l);
        longint          sa, sb, q, r, p;
        longint unsigned pu;
        logic [63:0]     v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin p = sa * sb; v = p; {h, l} = v; end
            2'd1: begin pu = {32'b0, a} * {32'b0, b}; v = pu; {h, l} = v; end
            default: begin
                if (b == 0) return 1'b1;
                if (o == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[W-1:0];
                    h = r[W-1:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
        return 1'b0;
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb, input bit with_mv);
        bit dz, seen;
        int cyc;
        dz = model(o, a, b, m_hi, m_lo);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        if (with_mv) begin mthi = 1'b1; mtlo = 1'b1; wdata = $urandom; end
        @(posedge clk);
        #1 start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rs = $urandom; rt = $urandom;
        seen = 1'b0;
        cyc = 1;
        while (cyc <= W + 3) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            if (disturb && cyc == 5) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = $urandom;
                #1 check("stall_busy", stall, 1);
            end
            @(posedge clk);
            #1 start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            cyc++;
        end
        check("done_seen", seen, 1);
        check("done_latency", cyc, dz ? 1 : W + 1);
        check("divzero", divzero, dz);
        @(posedge clk);
        @(negedge clk);
        check("busy_after", busy, 0);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic do_move(input bit wh, input bit wl, input logic [W-1:0] d);
        @(negedge clk);
        mthi = wh; mtlo = wl; wdata = d; mfreq = 1'b1;
        #1 check("stall_idle", stall, 0);
        @(posedge clk);
        #1 mthi = 1'b0; mtlo = 1'b0; mfreq = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        @(negedge clk);
        check("mv_hi", hi, m_hi);
        check("mv_lo", lo, m_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b;
        logic [1:0]   o;
        bit           dz;
        n_chk = 0; n_pass = 0;
        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mfreq = 1'b0;
        op = 2'd0; rs = '0; rt = '0; wdata = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_divzero", divzero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        #1 rst = 1'b0;

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_max_hi", m_hi, 32'hFFFF_FFFE);
        do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
        check("mult_neg_lo", m_lo, 32'hFFFF_FFEB);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_ovf_lo", m_lo, 32'h8000_0000);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_neg_lo", m_lo, 32'hFFFF_FFFD);
        do_op(2'd3, 32'd7, 32'd2, 0, 0);
        do_move(1, 0, 32'h1234);
        do_move(0, 1, 32'h5678);
        do_op(2'd2, 32'd5, 32'd0, 0, 0);
        check("dz_keep_hi", hi, 32'h1234);
        do_move(1, 1, 32'hCAFE_F00D);
        do_op(2'd1, 32'd9, 32'd11, 0, 1);

        // MFHI/MFLO waiting from cycle t+3 of a MULTU 6*7
        m_hi = 32'd0; m_lo = 32'd42;
        @(negedge clk);
        start = 1'b1; op = 2'd1; rs = 32'd6; rt = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= W + 2; cyc++) begin
            @(negedge clk);
            if (cyc >= 3) check("stall_mfreq", stall, (cyc <= W + 1) ? 1 : 0);
            else check("stall_noreq", stall, 0);
            if (cyc == W + 2) begin
                check("mfreq_lo", lo, 32'd42);
                check("mfreq_hi", hi, 32'd0);
            end
            @(posedge clk);
            #1 if (cyc == 2) mfreq = 1'b1;
        end
        mfreq = 1'b0;

        // reset in the middle of a DIVU
        @(negedge clk);
        start = 1'b1; op = 2'd3; rs = 32'd1000; rt = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        mfreq = 1'b1;
        #1 check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1 check("mid_rst_busy", busy, 0);
        check("mid_rst_stall", stall, 0);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        @(posedge clk);
        #1 rst = 1'b0; mfreq = 1'b0;
        m_hi = '0; m_lo = '0;
        do_op(2'd1, 32'd2, 32'd3, 0, 0);
        check("post_rst_lo", lo, 32'd6);

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) do_move(1'($urandom), 1'($urandom), $urandom);
            do_op(o, a, b, 1'($urandom), 1'($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
